// File: rtl/rgmii_rx_decode.sv
// RGMII receive decoder: turns DDR-captured RXD/RX_CTL pairs into a GMII byte stream
// (1000 DDR or 10/100 nibble pairing) and filters the in-band link status seen during idle.
module rgmii_rx_decode #(
    parameter int STATUS_FILTER = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rxd_q1,
    input  logic [3:0] rxd_q2,
    input  logic       ctl_q1,
    input  logic       ctl_q2,
    input  logic [1:0] speed,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_rx_valid,
    output logic       odd_nibble,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       link_full_duplex,
    output logic       status_change
);

    localparam logic [2:0] FILTER = 3'(STATUS_FILTER);

    typedef enum logic {
        NIB_LOW  = 1'b0,
        NIB_HIGH = 1'b1
    } nibState_e;

    logic       dv;
    logic       er;
    logic       statusSample;

    logic       modeGig_q,     modeGig_d;
    nibState_e  nibState_q,    nibState_d;
    logic [3:0] lowNibble_q,   lowNibble_d;
    logic       sticky_q,      sticky_d;
    logic       idleToggle_q,  idleToggle_d;

    logic [7:0] outByte_q,     outByte_d;
    logic       outDv_q,       outDv_d;
    logic       outEr_q,       outEr_d;
    logic       outValid_q,    outValid_d;
    logic       oddPulse_q,    oddPulse_d;

    logic [3:0] candidate_q,   candidate_d;
    logic [2:0] matchCnt_q,    matchCnt_d;
    logic [3:0] linkStatus_q,  linkStatus_d;
    logic       statusPulse_q, statusPulse_d;

    assign dv           = ctl_q1;
    assign er           = ctl_q1 ^ ctl_q2;
    assign statusSample = ~dv & ~er;

    // Speed is only re-latched between frames so a frame never changes decoding halfway.
    always_comb begin
        modeGig_d = modeGig_q;
        if (!dv) begin
            modeGig_d = (speed != 2'b00) && (speed != 2'b01);
        end
    end

    always_comb begin
        nibState_d   = nibState_q;
        lowNibble_d  = lowNibble_q;
        sticky_d     = sticky_q;
        idleToggle_d = idleToggle_q;
        outByte_d    = outByte_q;
        outDv_d      = outDv_q;
        outEr_d      = outEr_q;
        outValid_d   = 1'b0;
        oddPulse_d   = 1'b0;

        if (modeGig_q) begin
            nibState_d   = NIB_LOW;
            sticky_d     = 1'b0;
            idleToggle_d = 1'b0;
            outByte_d    = {rxd_q2, rxd_q1};
            outDv_d      = dv;
            outEr_d      = er;
            outValid_d   = 1'b1;
        end else begin
            unique case (nibState_q)
                NIB_LOW: begin
                    if (dv) begin
                        lowNibble_d  = rxd_q1;
                        sticky_d     = sticky_q | er;
                        idleToggle_d = 1'b0;
                        nibState_d   = NIB_HIGH;
                    end else begin
                        // Idle bytes go out at half rate, like real 10/100 byte timing.
                        idleToggle_d = ~idleToggle_q;
                        if (idleToggle_q) begin
                            outByte_d  = {rxd_q1, rxd_q1};
                            outDv_d    = 1'b0;
                            outEr_d    = er;
                            outValid_d = 1'b1;
                        end
                    end
                end
                NIB_HIGH: begin
                    nibState_d = NIB_LOW;
                    sticky_d   = 1'b0;
                    outValid_d = 1'b1;
                    outDv_d    = 1'b1;
                    if (dv) begin
                        outByte_d = {rxd_q1, lowNibble_q};
                        outEr_d   = sticky_q | er;
                    end else begin
                        outByte_d  = {4'h0, lowNibble_q};
                        outEr_d    = 1'b1;
                        oddPulse_d = 1'b1;
                    end
                end
                default: begin
                    nibState_d = NIB_LOW;
                end
            endcase
        end
    end

    // Link status only moves after FILTER matching idle samples; the pulse gate keeps
    // status_change from ever being high on two consecutive cycles.
    always_comb begin
        candidate_d   = candidate_q;
        matchCnt_d    = matchCnt_q;
        linkStatus_d  = linkStatus_q;
        statusPulse_d = 1'b0;

        if (statusSample) begin
            if ((matchCnt_q != 3'd0) && (rxd_q1 == candidate_q)) begin
                if (matchCnt_q < FILTER) begin
                    matchCnt_d = matchCnt_q + 3'd1;
                end
            end else begin
                candidate_d = rxd_q1;
                matchCnt_d  = 3'd1;
            end

            if ((matchCnt_d >= FILTER) && (candidate_d != linkStatus_q) && !statusPulse_q) begin
                linkStatus_d  = candidate_d;
                statusPulse_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modeGig_q     <= 1'b1;
            nibState_q    <= NIB_LOW;
            lowNibble_q   <= 4'h0;
            sticky_q      <= 1'b0;
            idleToggle_q  <= 1'b0;
            outByte_q     <= 8'h00;
            outDv_q       <= 1'b0;
            outEr_q       <= 1'b0;
            outValid_q    <= 1'b0;
            oddPulse_q    <= 1'b0;
            candidate_q   <= 4'h0;
            matchCnt_q    <= 3'd0;
            linkStatus_q  <= 4'h0;
            statusPulse_q <= 1'b0;
        end else begin
            modeGig_q     <= modeGig_d;
            nibState_q    <= nibState_d;
            lowNibble_q   <= lowNibble_d;
            sticky_q      <= sticky_d;
            idleToggle_q  <= idleToggle_d;
            outByte_q     <= outByte_d;
            outDv_q       <= outDv_d;
            outEr_q       <= outEr_d;
            outValid_q    <= outValid_d;
            oddPulse_q    <= oddPulse_d;
            candidate_q   <= candidate_d;
            matchCnt_q    <= matchCnt_d;
            linkStatus_q  <= linkStatus_d;
            statusPulse_q <= statusPulse_d;
        end
    end

    assign gmii_rxd         = outByte_q;
    assign gmii_rx_dv       = outDv_q;
    assign gmii_rx_er       = outEr_q;
    assign gmii_rx_valid    = outValid_q;
    assign odd_nibble       = oddPulse_q;
    assign link_up          = linkStatus_q[0];
    assign link_speed       = linkStatus_q[2:1];
    assign link_full_duplex = linkStatus_q[3];
    assign status_change    = statusPulse_q;

endmodule

// File: tb/tb_rgmii_rx_decode.sv
// Directed bench for rgmii_rx_decode: 1000/100 decoding, error paths, in-band status,
// mid-frame speed change and asynchronous reset.
module tb_rgmii_rx_decode;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] rxd_q1;
    logic [3:0] rxd_q2;
    logic       ctl_q1;
    logic       ctl_q2;
    logic [1:0] speed;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic       gmii_rx_valid;
    logic       odd_nibble;
    logic       link_up;
    logic [1:0] link_speed;
    logic       link_full_duplex;
    logic       status_change;

    int testsRun    = 0;
    int testsFailed = 0;

    rgmii_rx_decode #(.STATUS_FILTER(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rxd_q1           (rxd_q1),
        .rxd_q2           (rxd_q2),
        .ctl_q1           (ctl_q1),
        .ctl_q2           (ctl_q2),
        .speed            (speed),
        .gmii_rxd         (gmii_rxd),
        .gmii_rx_dv       (gmii_rx_dv),
        .gmii_rx_er       (gmii_rx_er),
        .gmii_rx_valid    (gmii_rx_valid),
        .odd_nibble       (odd_nibble),
        .link_up          (link_up),
        .link_speed       (link_speed),
        .link_full_duplex (link_full_duplex),
        .status_change    (status_change)
    );

    always #5 clk = ~clk;

    // Drive one cycle of capture-stage samples and land 1 ns after the edge that consumes them.
    task automatic applyStimulus(input logic [3:0] q1, input logic [3:0] q2,
                                 input logic c1, input logic c2);
        rxd_q1 = q1;
        rxd_q2 = q2;
        ctl_q1 = c1;
        ctl_q2 = c2;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [7:0] b;
        int dvCount;

        rst_n  = 1'b0;
        speed  = 2'b10;
        rxd_q1 = 4'h0;
        rxd_q2 = 4'h0;
        ctl_q1 = 1'b0;
        ctl_q2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_rxd",    gmii_rxd, 8'h00);
        checkOutput("rst_dv",     8'(gmii_rx_dv), 8'h0);
        checkOutput("rst_er",     8'(gmii_rx_er), 8'h0);
        checkOutput("rst_valid",  8'(gmii_rx_valid), 8'h0);
        checkOutput("rst_odd",    8'(odd_nibble), 8'h0);
        checkOutput("rst_up",     8'(link_up), 8'h0);
        checkOutput("rst_speed",  8'(link_speed), 8'h0);
        checkOutput("rst_fd",     8'(link_full_duplex), 8'h0);
        checkOutput("rst_sc",     8'(status_change), 8'h0);
        rst_n = 1'b1;

        repeat (3) applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("g_idle_dv",    8'(gmii_rx_dv), 8'h0);
        checkOutput("g_idle_valid", 8'(gmii_rx_valid), 8'h1);

        // 1000 Mb/s, 64-byte frame
        dvCount = 0;
        for (int i = 0; i < 64; i++) begin
            b = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : 8'(i - 8);
            applyStimulus(b[3:0], b[7:4], 1'b1, 1'b1);
            checkOutput("g_byte",  gmii_rxd, b);
            checkOutput("g_er",    8'(gmii_rx_er), 8'h0);
            checkOutput("g_valid", 8'(gmii_rx_valid), 8'h1);
            if (gmii_rx_dv && gmii_rx_valid) dvCount++;
        end
        applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("g_end_dv", 8'(gmii_rx_dv), 8'h0);
        checkOutput("g_dv_count", 8'(dvCount), 8'd64);

        // 1000 Mb/s, one errored byte mid-frame
        for (int i = 0; i < 6; i++) begin
            b = 8'h10 + 8'(i);
            applyStimulus(b[3:0], b[7:4], 1'b1, (i == 3) ? 1'b0 : 1'b1);
            checkOutput("gerr_byte", gmii_rxd, b);
            checkOutput("gerr_er",   8'(gmii_rx_er), (i == 3) ? 8'h1 : 8'h0);
            checkOutput("gerr_dv",   8'(gmii_rx_dv), 8'h1);
        end
        applyStimulus(4'hE, 4'hE, 1'b0, 1'b1);
        checkOutput("fc_rxd", gmii_rxd, 8'hEE);
        checkOutput("fc_dv",  8'(gmii_rx_dv), 8'h0);
        checkOutput("fc_er",  8'(gmii_rx_er), 8'h1);
        repeat (2) applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);

        // In-band status: 0xD twice updates, alternation does not
        applyStimulus(4'hD, 4'h0, 1'b0, 1'b0);
        checkOutput("st_first_up", 8'(link_up), 8'h0);
        checkOutput("st_first_sc", 8'(status_change), 8'h0);
        applyStimulus(4'hD, 4'h0, 1'b0, 1'b0);
        checkOutput("st_up",    8'(link_up), 8'h1);
        checkOutput("st_speed", 8'(link_speed), 8'h2);
        checkOutput("st_fd",    8'(link_full_duplex), 8'h1);
        checkOutput("st_sc",    8'(status_change), 8'h1);
        applyStimulus(4'hD, 4'h0, 1'b0, 1'b0);
        checkOutput("st_sc_pulse", 8'(status_change), 8'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i % 2 == 0) ? 4'hB : 4'hD, 4'h0, 1'b0, 1'b0);
            checkOutput("st_alt_sc",    8'(status_change), 8'h0);
            checkOutput("st_alt_speed", 8'(link_speed), 8'h2);
        end
        applyStimulus(4'hB, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'hB, 4'h0, 1'b0, 1'b0);
        checkOutput("st_b_speed", 8'(link_speed), 8'h1);
        checkOutput("st_b_sc",    8'(status_change), 8'h1);

        // Speed switched to 100 mid-frame: frame completes as 1000
        for (int i = 0; i < 8; i++) begin
            b = 8'hA0 + 8'(i);
            if (i == 3) speed = 2'b01;
            applyStimulus(b[3:0], b[7:4], 1'b1, 1'b1);
            checkOutput("sw_byte",  gmii_rxd, b);
            checkOutput("sw_valid", 8'(gmii_rx_valid), 8'h1);
        end
        repeat (4) applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);

        // 100 Mb/s, 8 nibbles 5..5,D
        for (int i = 0; i < 8; i++) begin
            applyStimulus((i == 7) ? 4'hD : 4'h5, 4'hA, 1'b1, 1'b1);
            checkOutput("f_valid", 8'(gmii_rx_valid), (i % 2 == 1) ? 8'h1 : 8'h0);
            if (i % 2 == 1) begin
                checkOutput("f_byte", gmii_rxd, (i == 7) ? 8'hD5 : 8'h55);
                checkOutput("f_dv",   8'(gmii_rx_dv), 8'h1);
                checkOutput("f_er",   8'(gmii_rx_er), 8'h0);
            end
        end
        applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("f_idle1_valid", 8'(gmii_rx_valid), 8'h0);
        checkOutput("f_idle1_odd",   8'(odd_nibble), 8'h0);
        applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("f_idle2_valid", 8'(gmii_rx_valid), 8'h1);
        checkOutput("f_idle2_dv",    8'(gmii_rx_dv), 8'h0);

        // 100 Mb/s, 7 nibbles 1..7: three bytes then odd-nibble error byte
        for (int i = 0; i < 7; i++) begin
            applyStimulus(4'(i + 1), 4'h0, 1'b1, 1'b1);
            if (i % 2 == 1) begin
                b = {4'(i + 1), 4'(i)};
                checkOutput("o_byte",  gmii_rxd, b);
                checkOutput("o_valid", 8'(gmii_rx_valid), 8'h1);
            end
        end
        applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("o_last_byte", gmii_rxd, 8'h07);
        checkOutput("o_last_dv",   8'(gmii_rx_dv), 8'h1);
        checkOutput("o_last_er",   8'(gmii_rx_er), 8'h1);
        checkOutput("o_last_vld",  8'(gmii_rx_valid), 8'h1);
        checkOutput("o_odd",       8'(odd_nibble), 8'h1);
        applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("o_odd_pulse", 8'(odd_nibble), 8'h0);
        checkOutput("o_post_vld",  8'(gmii_rx_valid), 8'h0);

        // 100 Mb/s sticky error on the low nibble only
        applyStimulus(4'h3, 4'h0, 1'b1, 1'b0);
        applyStimulus(4'hC, 4'h0, 1'b1, 1'b1);
        checkOutput("se_byte", gmii_rxd, 8'hC3);
        checkOutput("se_er",   8'(gmii_rx_er), 8'h1);
        applyStimulus(4'h1, 4'h0, 1'b1, 1'b1);
        applyStimulus(4'h1, 4'h0, 1'b1, 1'b1);
        checkOutput("se_clear_byte", gmii_rxd, 8'h11);
        checkOutput("se_clear_er",   8'(gmii_rx_er), 8'h0);

        // Asynchronous reset after one nibble of a 100 Mb/s frame
        repeat (4) applyStimulus(4'h6, 4'h0, 1'b0, 1'b0);
        checkOutput("pre_rst_speed", 8'(link_speed), 8'h3);
        applyStimulus(4'h9, 4'h0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #2;
        checkOutput("ar_rxd",   gmii_rxd, 8'h00);
        checkOutput("ar_valid", 8'(gmii_rx_valid), 8'h0);
        checkOutput("ar_speed", 8'(link_speed), 8'h0);
        checkOutput("ar_sc",    8'(status_change), 8'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'h2, 4'h0, 1'b1, 1'b1);
        checkOutput("rr_first_vld", 8'(gmii_rx_valid), 8'h0);
        applyStimulus(4'h3, 4'h0, 1'b1, 1'b1);
        checkOutput("rr_byte0", gmii_rxd, 8'h32);
        checkOutput("rr_vld0",  8'(gmii_rx_valid), 8'h1);
        applyStimulus(4'h4, 4'h0, 1'b1, 1'b1);
        applyStimulus(4'h5, 4'h0, 1'b1, 1'b1);
        checkOutput("rr_byte1", gmii_rxd, 8'h54);
        checkOutput("rr_er1",   8'(gmii_rx_er), 8'h0);
        applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
